fetcher_icache: RTL and testbench
=================================

Name: fetcher_icache

Overview:
- Instruction fetch stage sitting directly upstream of the program-memory controller, occupying one of its consumer ports.
- Accepts one PC at a time from the core scheduler and returns the 16-bit instruction.
- Includes a small direct-mapped instruction cache, one instruction per line; on a hit the controller is not touched.
- On a miss it runs the controller's read valid/ready handshake, fills the line and forwards the data.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, PC / program address width.
- PROGRAM_MEM_DATA_BITS, 16, instruction width.
- CACHE_LINES, 8, number of lines; power of 2, minimum 2. Index = pc[log2(CACHE_LINES)-1:0]; tag = remaining upper bits.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- req_valid  in  1  core requests a fetch.
- req_pc  in  PROGRAM_MEM_ADDR_BITS  fetch address.
- req_ready  out  1  fetcher can accept a request.
- resp_valid  out  1  instruction available.
- resp_instruction  out  PROGRAM_MEM_DATA_BITS  fetched instruction.
- resp_ready  in  1  core consumes the response.
- flush  in  1  invalidate all cache lines.
- mem_read_valid  out  1  to controller consumer_read_valid.
- mem_read_address  out  PROGRAM_MEM_ADDR_BITS  to controller consumer_read_address.
- mem_read_ready  in  1  from controller consumer_read_ready.
- mem_read_data  in  PROGRAM_MEM_DATA_BITS  from controller consumer_read_data.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state = IDLE; req_ready = 1; resp_valid = 0; resp_instruction = 0; mem_read_valid = 0; mem_read_address = 0; all line valid bits = 0. Tag and data arrays are not reset.
- All outputs are registered except req_ready, which is (state == IDLE).

States:
- IDLE
  - On req_valid: latch req_pc into pc_q and go to LOOKUP.
- LOOKUP
  - Hit (valid[idx] && tag[idx] == pc_q tag): resp_instruction <= data[idx]; resp_valid <= 1; go to RESPOND.
  - Miss: mem_read_valid <= 1; mem_read_address <= pc_q; go to MISS_WAIT.
- MISS_WAIT
  - Hold mem_read_valid and mem_read_address stable until mem_read_ready = 1.
  - On that edge:
    - mem_read_valid <= 0.
    - data[idx] <= mem_read_data; tag[idx] <= pc_q tag; valid[idx] <= 1.
    - resp_instruction <= mem_read_data; resp_valid <= 1.
    - Go to RESPOND.
  - Valid stays high during the cycle ready is first seen, so the controller samples valid && ready on that same edge and clears ready.
- RESPOND
  - Hold resp_valid and resp_instruction until resp_ready = 1; then resp_valid <= 0 and go to IDLE.

Latency:
- Hit: resp_valid high 2 cycles after the accept edge.
- Miss: 2 cycles + controller/memory latency.
- Back-to-back requests: 1 idle cycle minimum between a response handshake and the next accept.

Controller handshake rules:
- mem_read_valid never deasserts before mem_read_ready has been seen.
- mem_read_valid is never asserted while a prior mem_read_ready could still be high. Guaranteed because at least 2 cycles separate leaving MISS_WAIT and re-entering it.

Flush:
- Clears all valid bits on the next edge, in any state.
- Flush on the same edge as a miss fill: flush wins and the line stays invalid. The response is still delivered with the fetched data.
- Flush coinciding with accept: the request proceeds; the lookup then misses.

Other boundary conditions:
- PC aliasing (same index, different tag): the line is replaced on the fill.
- resp_ready asserted while resp_valid is low: ignored.
- Reset mid-miss: immediate return to IDLE with mem_read_valid = 0. The controller shares the same reset.

Optional Feature:
- Macro: FETCHER_STATS_EN.
- Defined:
  - Adds output ports hit_count[15:0] and miss_count[15:0].
  - Counters increment on LOOKUP hit / miss respectively and saturate at 16'hFFFF.
  - Reset to 0; flush does not clear them.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetcher_pkg:
  - fetcher_state_t enum: IDLE = 2'd0, LOOKUP = 2'd1, MISS_WAIT = 2'd2, RESPOND = 2'd3.
  - Helper functions index_bits(CACHE_LINES) and tag_bits(addr_bits, CACHE_LINES).
- Sub-module icache_array holds the tag, data and valid storage:
  - Combinational read port returning hit and data.
  - One write port (fill).
  - Flush input with priority over write.
- fetcher_icache contains the FSM, handshakes and optional counters.

Test Plan:
- Cold miss: reset, req_pc = 8'h05. Expect:
  - mem_read_valid = 1 with address 8'h05.
  - Bench memory returns 16'h1234 after 3 cycles.
  - resp_valid with 16'h1234.
  - mem_read_valid low the cycle after ready.
- Hit: repeat req_pc = 8'h05. Expect resp_valid = 16'h1234 two cycles after accept, with no mem_read_valid pulse.
- Alias eviction (CACHE_LINES = 8): fetch 8'h05, then 8'h0D (data 16'hBEEF) causing a miss, then 8'h05 causing a miss again and a memory re-read.
- Response backpressure: hold resp_ready = 0 for 5 cycles. Expect resp_valid and the data stable; req_ready = 0; a new req_valid is not accepted until after the handshake.
- Flush:
  - After filling 8'h05, pulse flush, then fetch 8'h05: miss.
  - Flush on the fill edge: the following fetch of the same PC also misses.
- Reset mid-miss: assert reset during MISS_WAIT. Expect next cycle mem_read_valid = 0, resp_valid = 0, req_ready = 1, and (with FETCHER_STATS_EN) hit_count = miss_count = 0.

Source files
------------

// File: rtl/fetcher_pkg.sv
// Shared types and sizing helpers for the instruction fetcher and its cache.
package fetcher_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_WAIT = 2'd2,
        RESPOND   = 2'd3
    } fetcher_state_t;

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int addr_bits, input int lines);
        return addr_bits - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped, one-instruction-per-line storage: combinational lookup,
// single fill port, and a flush that overrides a same-cycle fill.
module icache_array
    import fetcher_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LINES     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_hit,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data
);

    localparam int IDX_W = index_bits(LINES);
    localparam int TAG_W = tag_bits(ADDR_BITS, LINES);

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     valid_d;
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [DATA_BITS-1:0] data_mem [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_addr[IDX_W-1:0];
    assign rd_tag = rd_addr[ADDR_BITS-1:IDX_W];
    assign wr_idx = wr_addr[IDX_W-1:0];
    assign wr_tag = wr_addr[ADDR_BITS-1:IDX_W];

    always_comb begin
        rd_hit  = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
        rd_data = data_mem[rd_idx];
    end

    // A fill racing a flush still writes tag/data, but the line stays invalid.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/fetcher_icache.sv
// Instruction fetch stage with a direct-mapped icache in front of one program-memory
// controller port. Define FETCHER_STATS_EN to add saturating hit/miss counters.
module fetcher_icache
    import fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] req_pc,
    output logic                             req_ready,
    output logic                             resp_valid,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] resp_instruction,
    input  logic                             resp_ready,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data
`ifdef FETCHER_STATS_EN
    ,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
`endif
);

    fetcher_state_t                   state_q, state_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q, pc_d;
    logic                             resp_valid_q, resp_valid_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] resp_instr_q, resp_instr_d;
    logic                             mem_valid_q, mem_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;

    logic                             lk_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] lk_data;
    logic                             fill_en;

    icache_array #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .LINES     (CACHE_LINES)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .rd_addr (pc_q),
        .rd_hit  (lk_hit),
        .rd_data (lk_data),
        .wr_en   (fill_en),
        .wr_addr (pc_q),
        .wr_data (mem_read_data)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_valid_d = resp_valid_q;
        resp_instr_d = resp_instr_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        fill_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pc_d    = req_pc;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lk_hit) begin
                    resp_instr_d = lk_data;
                    resp_valid_d = 1'b1;
                    state_d      = RESPOND;
                end else begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = pc_q;
                    state_d     = MISS_WAIT;
                end
            end
            // Valid stays up through the ready cycle so the controller sees valid && ready.
            MISS_WAIT: begin
                if (mem_read_ready) begin
                    mem_valid_d  = 1'b0;
                    fill_en      = 1'b1;
                    resp_instr_d = mem_read_data;
                    resp_valid_d = 1'b1;
                    state_d      = RESPOND;
                end
            end
            RESPOND: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_instr_q <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_instr_q <= resp_instr_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    assign req_ready        = (state_q == IDLE);
    assign resp_valid       = resp_valid_q;
    assign resp_instruction = resp_instr_q;
    assign mem_read_valid   = mem_valid_q;
    assign mem_read_address = mem_addr_q;

`ifdef FETCHER_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] hit_q, hit_d;
    logic [15:0] miss_q, miss_d;

    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (state_q == LOOKUP) begin
            if (lk_hit) begin
                hit_d = sat_inc(hit_q);
            end else begin
                miss_d = sat_inc(miss_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_fetcher_icache.sv
// Scoreboard bench for fetcher_icache with a fixed-latency program-memory responder.
module tb_fetcher_icache;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [7:0]  req_pc;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_instruction;
    logic        resp_ready;
    logic        flush_req;
    logic        fill_flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_ready;
    logic [15:0] mem_rdata;
`ifdef FETCHER_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int vec;
    int errs;
    int mem_reads;
    int resp_cnt;
    logic [7:0] last_addr;
    bit flush_on_fill;
    logic [15:0] exp_q[$];

    fetcher_icache #(
        .PROGRAM_MEM_ADDR_BITS (8),
        .PROGRAM_MEM_DATA_BITS (16),
        .CACHE_LINES           (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_pc           (req_pc),
        .req_ready        (req_ready),
        .resp_valid       (resp_valid),
        .resp_instruction (resp_instruction),
        .resp_ready       (resp_ready),
        .flush            (flush_req | fill_flush),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_ready),
        .mem_read_data    (mem_rdata)
`ifdef FETCHER_STATS_EN
        ,
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_model(input logic [7:0] a);
        case (a)
            8'h05:   return 16'h1234;
            8'h0D:   return 16'hBEEF;
            default: return {a ^ 8'hA5, a};
        endcase
    endfunction

    // Program memory: ready for one cycle, 3 cycles after valid is first seen.
    initial begin
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        fill_flush = 1'b0;
        mem_reads  = 0;
        last_addr  = '0;
        resp_cnt   = 0;
        forever begin
            @(negedge clk);
            fill_flush = 1'b0;
            if (reset) begin
                resp_cnt  = 0;
                mem_ready = 1'b0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_read_valid) begin
                resp_cnt++;
                if (resp_cnt == 3) begin
                    resp_cnt   = 0;
                    mem_ready  = 1'b1;
                    mem_rdata  = mem_model(mem_read_address);
                    last_addr  = mem_read_address;
                    mem_reads++;
                    fill_flush = flush_on_fill;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Request one fetch and complete its response handshake; latency counts
    // edges from the cycle req_valid is raised to the edge resp_valid rises.
    task automatic do_fetch(input logic [7:0] pc, input bit fl, output logic [15:0] data,
                            output int lat, output int reads, output int mv_cycles,
                            output bit mv_low, output bit tmo);
        int r0;
        int n;
        r0 = mem_reads;
        tmo = 1'b0;
        mv_cycles = 0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_pc    = pc;
        flush_req = fl;
        @(posedge clk);
        lat = 1;
        #1;
        req_valid = 1'b0;
        flush_req = 1'b0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_read_valid) mv_cycles++;
        end
        if (!resp_valid) tmo = 1'b1;
        mv_low = !mem_read_valid;
        data   = resp_instruction;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        reads = mem_reads - r0;
    endtask

    task automatic test_reset();
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        vec++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        vec++; if (resp_instruction !== 16'h0) begin errs++; $display("FAIL reset_resp_instr got %h exp 0000", resp_instruction); end
        vec++; if (mem_read_valid !== 1'b0) begin errs++; $display("FAIL reset_mem_valid got %b exp 0", mem_read_valid); end
        vec++; if (mem_read_address !== 8'h0) begin errs++; $display("FAIL reset_mem_addr got %h exp 00", mem_read_address); end
    endtask

    task automatic test_cold_miss();
        logic [15:0] d, e;
        int lat, reads, mvc;
        bit mvl, tmo;
        exp_q.push_back(mem_model(8'h05));
        do_fetch(8'h05, 1'b0, d, lat, reads, mvc, mvl, tmo);
        e = exp_q.pop_front();
        vec++; if (tmo) begin errs++; $display("FAIL cold_timeout got timeout exp response"); end
        vec++; if (d !== e) begin errs++; $display("FAIL cold_data got %h exp %h", d, e); end
        vec++; if (last_addr !== 8'h05) begin errs++; $display("FAIL cold_addr got %h exp 05", last_addr); end
        vec++; if (reads !== 1) begin errs++; $display("FAIL cold_reads got %0d exp 1", reads); end
        vec++; if (lat !== 5) begin errs++; $display("FAIL cold_latency got %0d exp 5", lat); end
        vec++; if (!mvl) begin errs++; $display("FAIL cold_valid_drop got 1 exp 0"); end
    endtask

    task automatic test_hit();
        logic [15:0] d, e;
        int lat, reads, mvc;
        bit mvl, tmo;
        exp_q.push_back(16'h1234);
        do_fetch(8'h05, 1'b0, d, lat, reads, mvc, mvl, tmo);
        e = exp_q.pop_front();
        vec++; if (d !== e) begin errs++; $display("FAIL hit_data got %h exp %h", d, e); end
        vec++; if (lat !== 2) begin errs++; $display("FAIL hit_latency got %0d exp 2", lat); end
        vec++; if (reads !== 0 || mvc !== 0) begin errs++; $display("FAIL hit_no_mem got reads=%0d valid_cycles=%0d exp 0/0", reads, mvc); end
    endtask

    task automatic test_alias();
        logic [15:0] d, e;
        int lat, reads, mvc;
        bit mvl, tmo;
        exp_q.push_back(16'hBEEF);
        do_fetch(8'h0D, 1'b0, d, lat, reads, mvc, mvl, tmo);
        e = exp_q.pop_front();
        vec++; if (d !== e) begin errs++; $display("FAIL alias_0d_data got %h exp %h", d, e); end
        vec++; if (reads !== 1) begin errs++; $display("FAIL alias_0d_reads got %0d exp 1", reads); end
        exp_q.push_back(16'h1234);
        do_fetch(8'h05, 1'b0, d, lat, reads, mvc, mvl, tmo);
        e = exp_q.pop_front();
        vec++; if (d !== e) begin errs++; $display("FAIL alias_05_data got %h exp %h", d, e); end
        vec++; if (reads !== 1 || last_addr !== 8'h05) begin errs++; $display("FAIL alias_05_reread got reads=%0d addr=%h exp 1/05", reads, last_addr); end
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        int r0, n;
        bit stable, blocked;
        r0 = mem_reads;
        exp_q.push_back(16'h1234);
        @(negedge clk);
        req_valid = 1'b1;
        req_pc    = 8'h05;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        stable  = 1'b1;
        blocked = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_valid = 1'b1;
                req_pc    = 8'h0D;
            end
            if (resp_valid !== 1'b1 || resp_instruction !== e) stable = 1'b0;
            if (req_ready !== 1'b0) blocked = 1'b0;
        end
        vec++; if (!stable) begin errs++; $display("FAIL bp_stable got valid=%b data=%h exp 1/%h", resp_valid, resp_instruction, e); end
        vec++; if (!blocked) begin errs++; $display("FAIL bp_req_ready got 1 exp 0 while holding"); end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errs++; $display("FAIL bp_release got ready=%b valid=%b exp 1/0", req_ready, resp_valid); end
        exp_q.push_back(16'hBEEF);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = exp_q.pop_front();
        vec++; if (resp_instruction !== e || !resp_valid) begin errs++; $display("FAIL bp_next_data got %h exp %h", resp_instruction, e); end
        vec++; if (mem_reads - r0 !== 1) begin errs++; $display("FAIL bp_next_reads got %0d exp 1", mem_reads - r0); end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [15:0] d, e;
        int lat, reads, mvc;
        bit mvl, tmo;
        do_fetch(8'h05, 1'b0, d, lat, reads, mvc, mvl, tmo);
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        exp_q.push_back(16'h1234);
        do_fetch(8'h05, 1'b0, d, lat, reads, mvc, mvl, tmo);
        e = exp_q.pop_front();
        vec++; if (reads !== 1 || d !== e) begin errs++; $display("FAIL flush_pulse got reads=%0d data=%h exp 1/%h", reads, d, e); end
        flush_on_fill = 1'b1;
        exp_q.push_back(mem_model(8'h22));
        do_fetch(8'h22, 1'b0, d, lat, reads, mvc, mvl, tmo);
        flush_on_fill = 1'b0;
        e = exp_q.pop_front();
        vec++; if (d !== e) begin errs++; $display("FAIL flush_fill_data got %h exp %h", d, e); end
        exp_q.push_back(mem_model(8'h22));
        do_fetch(8'h22, 1'b0, d, lat, reads, mvc, mvl, tmo);
        e = exp_q.pop_front();
        vec++; if (reads !== 1 || d !== e) begin errs++; $display("FAIL flush_fill_refetch got reads=%0d data=%h exp 1/%h", reads, d, e); end
        do_fetch(8'h05, 1'b0, d, lat, reads, mvc, mvl, tmo);
        exp_q.push_back(16'h1234);
        do_fetch(8'h05, 1'b1, d, lat, reads, mvc, mvl, tmo);
        e = exp_q.pop_front();
        vec++; if (reads !== 1 || d !== e) begin errs++; $display("FAIL flush_accept got reads=%0d data=%h exp 1/%h", reads, d, e); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d, e;
        logic [7:0] pc;
        int lat, reads, mvc;
        bit mvl, tmo;
        for (int i = 0; i < 6; i++) begin
            pc = 8'($urandom_range(0, 255));
            exp_q.push_back(mem_model(pc));
            exp_q.push_back(mem_model(pc));
            do_fetch(pc, 1'b0, d, lat, reads, mvc, mvl, tmo);
            e = exp_q.pop_front();
            vec++; if (d !== e) begin errs++; $display("FAIL b2b_first pc=%h got %h exp %h", pc, d, e); end
            do_fetch(pc, 1'b0, d, lat, reads, mvc, mvl, tmo);
            e = exp_q.pop_front();
            vec++; if (d !== e || reads !== 0 || lat !== 2) begin errs++; $display("FAIL b2b_second pc=%h got %h reads=%0d lat=%0d exp %h 0 2", pc, d, reads, lat, e); end
        end
    endtask

    task automatic test_reset_mid_miss();
        logic [15:0] d, e;
        int lat, reads, mvc, n;
        bit mvl, tmo;
        @(negedge clk);
        req_valid = 1'b1;
        req_pc    = 8'h40;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_read_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        vec++; if (mem_read_valid !== 1'b1) begin errs++; $display("FAIL midmiss_enter got %b exp 1", mem_read_valid); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        vec++; if (mem_read_valid !== 1'b0) begin errs++; $display("FAIL midmiss_mem_valid got %b exp 0", mem_read_valid); end
        vec++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL midmiss_resp_valid got %b exp 0", resp_valid); end
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL midmiss_req_ready got %b exp 1", req_ready); end
`ifdef FETCHER_STATS_EN
        vec++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin errs++; $display("FAIL midmiss_stats got %h/%h exp 0000/0000", hit_count, miss_count); end
`endif
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(16'h1234);
        do_fetch(8'h05, 1'b0, d, lat, reads, mvc, mvl, tmo);
        e = exp_q.pop_front();
        vec++; if (reads !== 1 || d !== e) begin errs++; $display("FAIL midmiss_refetch got reads=%0d data=%h exp 1/%h", reads, d, e); end
`ifdef FETCHER_STATS_EN
        vec++; if (hit_count !== 16'h0 || miss_count !== 16'h1) begin errs++; $display("FAIL stats_after got %h/%h exp 0000/0001", hit_count, miss_count); end
`endif
    endtask

    initial begin
        vec           = 0;
        errs          = 0;
        flush_on_fill = 1'b0;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_pc        = '0;
        resp_ready    = 1'b0;
        flush_req     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_cold_miss();
        test_hit();
        test_alias();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid_miss();
        vec++; if (exp_q.size() != 0) begin errs++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
